// File: rtl/rope_step_scheduler.sv
// rtl/rope_step_scheduler.sv - one rope simulation step: Verlet pulse, then ITERATIONS relaxation passes
// over every adjacent node pair through a shared solver, committing each result with a per-node fix enable.
module rope_step_scheduler #(
  parameter int NUM_NODES  = 8,
  parameter int ITERATIONS = 4,
  parameter int IDX_W      = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 frame_tick,
  output logic                 verlet_state,
  output logic                 solver_start,
  output logic [IDX_W-1:0]     solver_idx_a,
  output logic [IDX_W-1:0]     solver_idx_b,
  input  logic                 solver_done,
  output logic                 fix_constraint_state,
  output logic [NUM_NODES-1:0] fix_en,
  output logic                 busy,
  output logic                 step_done,
  output logic                 overrun,
  output logic                 solver_error
);

  localparam int IT_W = $clog2(ITERATIONS) + 1;
  localparam int TM_W = $clog2(TIMEOUT) + 1;
  localparam logic [IDX_W-1:0]     LAST_SEG = IDX_W'(NUM_NODES - 2);
  localparam logic [IT_W-1:0]      LAST_IT  = IT_W'(ITERATIONS - 1);
  localparam logic [TM_W-1:0]      LAST_TM  = TM_W'(TIMEOUT - 1);
  localparam logic [NUM_NODES-1:0] PAIR     = NUM_NODES'(3);
  // Node 0 is the anchor and must never be rewritten.
  localparam logic [NUM_NODES-1:0] MOVABLE  = ~NUM_NODES'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_VERLET, S_SOLVE_REQ, S_SOLVE_WAIT, S_FIX, S_NEXT, S_DONE
  } state_t;

  state_t               r_state, w_next;
  logic [IDX_W-1:0]     r_seg, w_seg_next;
  logic [IT_W-1:0]      r_iter, w_iter_next;
  logic [TM_W-1:0]      r_timer, w_timer_next;
  logic                 w_timeout;

  logic                 r_verlet, r_start, r_fix, r_busy, r_done, r_overrun, r_error;
  logic [IDX_W-1:0]     r_idx_a, r_idx_b;
  logic [NUM_NODES-1:0] r_fix_en;

  always_comb begin
    w_next       = r_state;
    w_seg_next   = r_seg;
    w_iter_next  = r_iter;
    w_timer_next = r_timer;
    w_timeout    = 1'b0;
    unique case (r_state)
      S_IDLE: if (frame_tick) w_next = S_VERLET;
      S_VERLET: begin
        w_seg_next  = '0;
        w_iter_next = '0;
        w_next      = S_SOLVE_REQ;
      end
      S_SOLVE_REQ: begin
        w_timer_next = '0;
        w_next       = S_SOLVE_WAIT;
      end
      S_SOLVE_WAIT: begin
        if (solver_done) begin
          w_next = S_FIX;
        end else if (r_timer == LAST_TM) begin
          w_timeout = 1'b1;
          w_next    = S_IDLE;
        end else begin
          w_timer_next = r_timer + 1'b1;
        end
      end
      S_FIX: w_next = S_NEXT;
      S_NEXT: begin
        if (r_seg == LAST_SEG) begin
          w_seg_next = '0;
          if (r_iter == LAST_IT) begin
            w_next = S_DONE;
          end else begin
            w_iter_next = r_iter + 1'b1;
            w_next      = S_SOLVE_REQ;
          end
        end else begin
          w_seg_next = r_seg + 1'b1;
          w_next     = S_SOLVE_REQ;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Strobes are decoded from the next state so they line up with the state they belong to.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_seg     <= '0;
      r_iter    <= '0;
      r_timer   <= '0;
      r_verlet  <= 1'b0;
      r_start   <= 1'b0;
      r_fix     <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_overrun <= 1'b0;
      r_error   <= 1'b0;
      r_idx_a   <= '0;
      r_idx_b   <= '0;
      r_fix_en  <= '0;
    end else begin
      r_state  <= w_next;
      r_seg    <= w_seg_next;
      r_iter   <= w_iter_next;
      r_timer  <= w_timer_next;
      r_verlet <= (w_next == S_VERLET);
      r_start  <= (w_next == S_SOLVE_REQ);
      r_fix    <= (w_next == S_FIX);
      r_done   <= (w_next == S_DONE);
      r_busy   <= (w_next != S_IDLE);
      r_fix_en <= (w_next == S_FIX) ? ((PAIR << r_seg) & MOVABLE) : '0;
      if (w_next == S_SOLVE_REQ) begin
        r_idx_a <= w_seg_next;
        r_idx_b <= w_seg_next + 1'b1;
      end
      if (frame_tick && (r_state != S_IDLE)) r_overrun <= 1'b1;
      if (w_timeout) r_error <= 1'b1;
    end
  end

  assign verlet_state         = r_verlet;
  assign solver_start         = r_start;
  assign solver_idx_a         = r_idx_a;
  assign solver_idx_b         = r_idx_b;
  assign fix_constraint_state = r_fix;
  assign fix_en               = r_fix_en;
  assign busy                 = r_busy;
  assign step_done            = r_done;
  assign overrun              = r_overrun;
  assign solver_error         = r_error;

endmodule

// File: tb/tb_rope_step_scheduler.sv
// tb/tb_rope_step_scheduler.sv - randomized bench; reference model expands each accepted step into
// its expected per-cycle output trace and a reactive solver answers starts with chosen latencies.
module tb_rope_step_scheduler;
  localparam int N  = 8;
  localparam int IT = 4;
  localparam int IW = 4;
  localparam int TO = 64;

  logic          clk = 1'b0;
  logic          reset, frame_tick, solver_done;
  logic          verlet_state, solver_start, fix_constraint_state, busy, step_done, overrun, solver_error;
  logic [IW-1:0] solver_idx_a, solver_idx_b;
  logic [N-1:0]  fix_en;

  rope_step_scheduler #(.NUM_NODES(N), .ITERATIONS(IT), .IDX_W(IW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .verlet_state(verlet_state),
    .solver_start(solver_start), .solver_idx_a(solver_idx_a), .solver_idx_b(solver_idx_b),
    .solver_done(solver_done), .fix_constraint_state(fix_constraint_state), .fix_en(fix_en),
    .busy(busy), .step_done(step_done), .overrun(overrun), .solver_error(solver_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit verlet, start, fix, busy, done, is_wait, chk_idx, err_after;
    int idx;
    int fen;
  } vec_t;

  vec_t exp_q[$];
  int   lat_q[$];
  int   total = 0, bad = 0, cyc = 0;
  bit   exp_ov = 0, exp_err = 0, post_rst = 1;
  int   cfg_lat = 1, cfg_hang = -1;
  bit   cfg_rand_hang = 0, cfg_noise = 0;
  int   resp_cnt = 0;
  int   verlet_cyc, done_cyc, done_count, start_cnt, fix_seen, err_cyc, idle_cyc, fix_first, fix_last;
  bit   prev_busy = 0, prev_err = 0;
  int   t0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, got, want);
    end
  endtask

  function automatic vec_t blank();
    vec_t v;
    v.verlet = 0; v.start = 0; v.fix = 0; v.busy = 0; v.done = 0;
    v.is_wait = 0; v.chk_idx = 0; v.err_after = 0; v.idx = 0; v.fen = 0;
    return v;
  endfunction

  // Expected trace of a whole step: pulse, then start/waits/commit/advance per segment, then done.
  task automatic gen_step();
    vec_t v;
    int   n = 0;
    int   lat, nw;
    int   hang = cfg_hang;
    if (cfg_rand_hang) hang = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 27)) : -1;
    v = blank(); v.busy = 1; v.verlet = 1; exp_q.push_back(v);
    for (int it = 0; it < IT; it++) begin
      for (int s = 0; s < N - 1; s++) begin
        lat = (cfg_lat > 0) ? cfg_lat : int'($urandom_range(1, 6));
        if (n == hang) lat = 0;
        lat_q.push_back(lat);
        v = blank(); v.busy = 1; v.start = 1; v.chk_idx = 1; v.idx = s; exp_q.push_back(v);
        nw = (lat == 0) ? TO : lat;
        for (int w = 0; w < nw; w++) begin
          v = blank(); v.busy = 1; v.is_wait = 1; v.chk_idx = 1; v.idx = s;
          v.err_after = (lat == 0) && (w == TO - 1);
          exp_q.push_back(v);
        end
        if (lat == 0) return;
        v = blank(); v.busy = 1; v.fix = 1; v.chk_idx = 1; v.idx = s;
        v.fen = ((1 << s) | (1 << (s + 1))) & ~1;
        exp_q.push_back(v);
        v = blank(); v.busy = 1; exp_q.push_back(v);
        n++;
      end
    end
    v = blank(); v.busy = 1; v.done = 1; exp_q.push_back(v);
  endtask

  task automatic clr_track();
    verlet_cyc = -1; done_cyc = -1; done_count = 0; start_cnt = 0;
    fix_seen = 0; err_cyc = -1; idle_cyc = -1; fix_first = -1; fix_last = -1;
  endtask

  // Called at a falling edge: check cycle 'cyc', then drive inputs sampled at the next rising edge.
  task automatic cyc_step(input bit tick, input bit rst);
    vec_t e;
    bit   rd;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else e = blank();

    if (post_rst)
      chk("reset_zero", {verlet_state, solver_start, fix_constraint_state, busy, step_done,
                         overrun, solver_error, solver_idx_a, solver_idx_b, fix_en}, 0);
    chk("verlet_state", verlet_state, e.verlet);
    chk("solver_start", solver_start, e.start);
    chk("fix_strobe", fix_constraint_state, e.fix);
    chk("busy", busy, e.busy);
    chk("step_done", step_done, e.done);
    chk("overrun", overrun, exp_ov);
    chk("solver_error", solver_error, exp_err);
    chk("strobe_mutex", (verlet_state + solver_start + fix_constraint_state) <= 1, 1);
    if (e.chk_idx) begin
      chk("idx_a", solver_idx_a, e.idx);
      chk("idx_b", solver_idx_b, e.idx + 1);
    end
    if (e.fix) chk("fix_en", fix_en, e.fen);

    if (verlet_state) verlet_cyc = cyc;
    if (step_done) begin done_cyc = cyc; done_count++; end
    if (solver_start) start_cnt++;
    if (fix_constraint_state) begin
      if (fix_seen == 0) fix_first = int'(fix_en);
      fix_last = int'(fix_en);
      fix_seen++;
    end
    if (solver_error && !prev_err) err_cyc = cyc;
    if (!busy && prev_busy) idle_cyc = cyc;
    prev_busy = busy;
    prev_err  = solver_error;

    rd = 0;
    if (resp_cnt > 0) begin
      resp_cnt--;
      rd = (resp_cnt == 0);
    end
    if (solver_start && lat_q.size() > 0) resp_cnt = lat_q.pop_front();
    solver_done = rd | (cfg_noise && !e.is_wait && ($urandom_range(0, 3) == 0));

    frame_tick = tick;
    reset      = rst;
    if (rst) begin
      exp_q.delete(); lat_q.delete();
      resp_cnt = 0; solver_done = 0; exp_ov = 0; exp_err = 0; post_rst = 1;
    end else begin
      post_rst = 0;
      if (e.err_after) exp_err = 1;
      if (tick) begin
        if (e.busy) exp_ov = 1;
        else gen_step();
      end
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc_step(0, 0);
  endtask

  initial begin
    bit rst, tick;
    reset = 1; frame_tick = 0; solver_done = 0;
    @(negedge clk);
    cyc_step(0, 1); cyc_step(0, 1); run(3);

    // Nominal step, solver answers one cycle after each start
    cfg_lat = 1; clr_track(); t0 = cyc; cyc_step(1, 0);
    chk("model_len_lat1", exp_q.size(), 114);
    run(120);
    chk("s1_verlet_at", verlet_cyc - t0, 1);
    chk("s1_done_at", done_cyc - t0, 114);
    chk("s1_idle_at", idle_cyc - t0, 115);
    chk("s1_starts", start_cnt, 28);
    chk("s1_fix_first", fix_first, 32'h02);
    chk("s1_fix_last", fix_last, 32'hC0);
    chk("s1_done_count", done_count, 1);

    // Slow solver: five cycles per answer
    cfg_lat = 5; clr_track(); t0 = cyc; cyc_step(1, 0);
    chk("model_len_lat5", exp_q.size(), 226);
    run(235);
    chk("s2_done_at", done_cyc - t0, 226);
    chk("s2_starts", start_cnt, 28);

    // Solver silent on the third segment, then a clean step
    cfg_lat = 1; cfg_hang = 2; clr_track(); t0 = cyc; cyc_step(1, 0);
    run(90);
    chk("s3_err_at", err_cyc - t0, 75);
    chk("s3_idle_at", idle_cyc - t0, 75);
    chk("s3_no_done", done_count, 0);
    cfg_hang = -1; clr_track(); t0 = cyc; cyc_step(1, 0);
    run(120);
    chk("s3b_done_at", done_cyc - t0, 114);
    chk("s3b_fix_first", fix_first, 32'h02);
    chk("s3b_starts", start_cnt, 28);

    // Second tick mid-step is dropped
    clr_track(); t0 = cyc; cyc_step(1, 0);
    run(49); cyc_step(1, 0); run(70);
    chk("s4_done_at", done_cyc - t0, 114);
    chk("s4_done_count", done_count, 1);
    chk("s4_overrun", overrun, 1);

    // Reset in the middle of a step
    clr_track(); t0 = cyc; cyc_step(1, 0);
    run(39); cyc_step(0, 1);
    run(150);
    chk("s6_no_done", done_count, 0);
    chk("s6_flags", {overrun, solver_error}, 0);

    // Random ticks, latencies, hangs, spurious done and resets
    cfg_lat = 0; cfg_rand_hang = 1; cfg_noise = 1;
    for (int i = 0; i < 6000; i++) begin
      rst  = ($urandom_range(0, 1999) == 0);
      tick = !rst && ($urandom_range(0, 59) == 0);
      cyc_step(tick, rst);
    end
    cfg_noise = 0;
    run(300);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
